serial_load_arbiter: RTL and testbench

Sequences ASCII program loading into the UK101 serial receive path, sharing that path between two sources: OSD file download (ioctl, index 0, "Load Ascii") and the external UART deserializer. File bytes are buffered in a FIFO with `ioctl_wait` backpressure and paced out with inter-character and end-of-line gaps so BASIC/monitor can keep up. The block sits between `hps_io` / UART receiver and the ACIA receive-byte interface inside `uk101`.

---
 rtl/serial_load_arbiter_if.sv | 28 ++
 rtl/serial_load_arbiter.sv | 176 +++++++++++++++++
 tb/tb_serial_load_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_load_arbiter_if.sv
// Handshake bundle between the OSD/UART byte sources and the UK101 ACIA receive side.
interface serial_load_arbiter_if;
    logic       load_from;
    logic       ioctl_download;
    logic [7:0] ioctl_index;
    logic       ioctl_wr;
    logic [7:0] ioctl_data;
    logic       ioctl_wait;
    logic [7:0] uart_data;
    logic       uart_valid;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       overrun;

    modport master (
        output load_from, ioctl_download, ioctl_index, ioctl_wr, ioctl_data,
        output uart_data, uart_valid, rx_ready,
        input  ioctl_wait, rx_data, rx_valid, busy, overrun
    );

    modport slave (
        input  load_from, ioctl_download, ioctl_index, ioctl_wr, ioctl_data,
        input  uart_data, uart_valid, rx_ready,
        output ioctl_wait, rx_data, rx_valid, busy, overrun
    );
endinterface

// File: rtl/serial_load_arbiter.sv
// Paced ASCII file loader sharing the ACIA receive path with the UART deserializer.
// Optional feature: define SERIAL_LOAD_LF_FILTER_EN to drop 0x0A file bytes at the FIFO input.
module serial_load_arbiter #(
    parameter int FIFO_AW  = 4,
    parameter int CHAR_GAP = 4800,
    parameter int LINE_GAP = 480000,
    parameter int GAP_W    = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_load_arbiter_if.slave  bus
);
    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL   = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] WAIT_LVL   = (FIFO_AW+1)'(DEPTH - 2);
    localparam logic [GAP_W-1:0] CHAR_GAP_V = GAP_W'(CHAR_GAP);
    localparam logic [GAP_W-1:0] LINE_GAP_V = GAP_W'(LINE_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO   = GAP_W'(0);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_t;

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r, wr_base_s, rd_base_s;
    logic [FIFO_AW:0]   count_r, count_base_s, count_s;
    logic               qual_r, wait_r, busy_r, overrun_r, overrun_s;
    logic               qual_s, flush_s, push_s, pop_s, accept_s, lf_drop_s;
    state_t             state_r, state_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               src_r, src_s;      // 0 = file FSM owns rx_*, 1 = UART holding register
    logic [7:0]         rx_data_r, rx_data_s;
    logic               rx_valid_r, rx_valid_s;

    // FIFO input qualification, download-start flush and next occupancy
    always_comb begin
        qual_s  = bus.ioctl_download && (bus.ioctl_index == 8'h00);
        flush_s = qual_s && !qual_r;
`ifdef SERIAL_LOAD_LF_FILTER_EN
        lf_drop_s = (bus.ioctl_data == 8'h0A);
`else
        lf_drop_s = 1'b0;
`endif
        push_s   = !bus.load_from && qual_s && bus.ioctl_wr && !lf_drop_s &&
                   (flush_s || (count_r != FULL_LVL));
        accept_s = rx_valid_r && bus.rx_ready;
        if (flush_s) begin
            wr_base_s    = {FIFO_AW{1'b0}};
            rd_base_s    = {FIFO_AW{1'b0}};
            count_base_s = {(FIFO_AW+1){1'b0}};
        end else begin
            wr_base_s    = wr_ptr_r;
            rd_base_s    = rd_ptr_r;
            count_base_s = count_r;
        end
        count_s = count_base_s + {{FIFO_AW{1'b0}}, push_s} - {{FIFO_AW{1'b0}}, pop_s};
    end

    // Source ownership, pacing FSM and UART holding register
    always_comb begin
        state_s    = state_r;
        gap_s      = gap_r;
        src_s      = src_r;
        rx_data_s  = rx_data_r;
        rx_valid_s = rx_valid_r;
        overrun_s  = overrun_r;
        pop_s      = 1'b0;
        if (!src_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.load_from) begin
                        src_s = 1'b1;
                    end else if ((count_r != {(FIFO_AW+1){1'b0}}) && !flush_s) begin
                        pop_s      = 1'b1;
                        rx_data_s  = mem_r[rd_ptr_r];
                        rx_valid_s = 1'b1;
                        state_s    = ST_SEND;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (accept_s) begin
                        rx_valid_s = 1'b0;
                        gap_s      = (rx_data_r == 8'h0D) ? LINE_GAP_V : CHAR_GAP_V;
                        state_s    = ST_GAP;
                    end else begin
                        state_s = ST_SEND;
                    end
                end
                ST_GAP: begin
                    // A pending switch to UART abandons the remaining file pacing
                    if (bus.load_from || (gap_r <= GAP_ONE)) begin
                        gap_s   = GAP_ZERO;
                        state_s = ST_IDLE;
                        src_s   = bus.load_from;
                    end else begin
                        gap_s = gap_r - GAP_ONE;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    gap_s      = GAP_ZERO;
                    rx_valid_s = 1'b0;
                end
            endcase
        end else begin
            state_s = ST_IDLE;
            gap_s   = GAP_ZERO;
            if (!bus.load_from && !rx_valid_r) begin
                src_s = 1'b0;
            end else if (bus.uart_valid) begin
                if (!rx_valid_r || accept_s) begin
                    rx_data_s  = bus.uart_data;
                    rx_valid_s = 1'b1;
                end else begin
                    overrun_s = 1'b1;
                end
            end else if (accept_s) begin
                rx_valid_s = 1'b0;
            end else begin
                rx_valid_s = rx_valid_r;
            end
        end
    end

    // FIFO storage; contents are don't-care while the occupancy count is zero
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_base_s] <= bus.ioctl_data;
        end
    end

    // FIFO pointers, occupancy, download-edge detector and backpressure flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW+1){1'b0}};
            qual_r   <= 1'b0;
            wait_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_base_s + {{(FIFO_AW-1){1'b0}}, push_s};
            rd_ptr_r <= rd_base_s + {{(FIFO_AW-1){1'b0}}, pop_s};
            count_r  <= count_s;
            qual_r   <= qual_s;
            wait_r   <= (count_s >= WAIT_LVL);
        end
    end

    // FSM state, gap counter and registered receive-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            gap_r      <= GAP_ZERO;
            src_r      <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            gap_r      <= gap_s;
            src_r      <= src_s;
            rx_data_r  <= rx_data_s;
            rx_valid_r <= rx_valid_s;
            busy_r     <= (count_s != {(FIFO_AW+1){1'b0}}) || (state_s != ST_IDLE);
            overrun_r  <= overrun_s;
        end
    end

    assign bus.ioctl_wait = wait_r;
    assign bus.rx_data    = rx_data_r;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_serial_load_arbiter.sv
// Self-checking bench for serial_load_arbiter with shortened gaps and a timing reference model.
module tb_serial_load_arbiter;
    localparam int CG  = 8;
    localparam int LG  = 40;
    localparam int HOR = 1200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    serial_load_arbiter_if bus();

    serial_load_arbiter #(.FIFO_AW(4), .CHAR_GAP(CG), .LINE_GAP(LG), .GAP_W(20)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // accepted bytes with the cycle rx_valid first rose and the cycle of acceptance
    logic [7:0] acc_d[$];
    int         acc_a[$];
    int         acc_r[$];
    bit         in_hold = 1'b0;
    int         rise_c = 0;

    always @(negedge clk) begin
        if (reset) begin
            in_hold = 1'b0;
        end else if (bus.rx_valid) begin
            if (!in_hold) begin
                in_hold = 1'b1;
                rise_c  = cyc;
            end
            if (bus.rx_ready) begin
                acc_d.push_back(bus.rx_data);
                acc_a.push_back(cyc);
                acc_r.push_back(rise_c);
                in_hold = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acc_d.delete();
        acc_a.delete();
        acc_r.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ioctl_wr = 1'b0;
        bus.uart_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic file_write(input logic [7:0] d);
        bus.ioctl_wr = 1'b1;
        bus.ioctl_data = d;
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic uart_pulse(input logic [7:0] d);
        bus.uart_valid = 1'b1;
        bus.uart_data = d;
        tick();
        bus.uart_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        got = {bus.ioctl_wait, bus.rx_data, bus.rx_valid, bus.busy, bus.overrun};
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", got, 12'h000);
        end
        tick();
        reset = 1'b0;
        bus.load_from = 1'b0;
        bus.ioctl_download = 1'b1;
        bus.rx_ready = 1'b0;
        tick();
        file_write(8'hA1);
        file_write(8'hA2);
        file_write(8'hA3);
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hA1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_send: got valid=%b data=%h busy=%b expected 1 a1 1",
                     bus.rx_valid, bus.rx_data, bus.busy);
        end
        #1 reset = 1'b1;
        bus.ioctl_download = 1'b0;
        #1;
        got = {bus.ioctl_wait, bus.rx_data, bus.rx_valid, bus.busy, bus.overrun};
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_send: got %h expected %h", got, 12'h000);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        n_checks++;
        if (bus.rx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fifo_empty: got valid=%b busy=%b expected 0 0", bus.rx_valid, bus.busy);
        end
    endtask

    task automatic test_file_ar();
        int w;
        int t;
        do_reset();
        bus.load_from = 1'b0;
        bus.ioctl_download = 1'b1;
        bus.rx_ready = 1'b1;
        tick();
        clear_mon();
        w = cyc;
        file_write(8'h41);
        file_write(8'h0D);
        for (int i = 0; i < 200 && acc_d.size() < 2; i++) tick();
        n_checks++;
        if (acc_d.size() != 2) begin
            n_fail++;
            $display("FAIL file_ar_count: got %0d expected 2", acc_d.size());
            return;
        end
        n_checks++;
        if (acc_d[0] !== 8'h41 || acc_r[0] != w + 2) begin
            n_fail++;
            $display("FAIL file_ar_first: got %h@%0d expected 41@%0d", acc_d[0], acc_r[0], w + 2);
        end
        n_checks++;
        if (acc_d[1] !== 8'h0D || acc_r[1] != acc_a[0] + CG + 2) begin
            n_fail++;
            $display("FAIL file_ar_cr: got %h@%0d expected 0d@%0d", acc_d[1], acc_r[1], acc_a[0] + CG + 2);
        end
        t = acc_a[1] + LG;
        for (int i = 0; i < 200 && cyc < t; i++) tick();
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL file_ar_busy_gap: got %b expected 1", bus.busy);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL file_ar_busy_clear: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_backpressure();
        int nw = 0;
        do_reset();
        bus.load_from = 1'b0;
        bus.ioctl_download = 1'b1;
        bus.rx_ready = 1'b0;
        tick();
        clear_mon();
        for (int i = 0; i < 40 && nw < 20 && !bus.ioctl_wait; i++) begin
            file_write(8'h10 + 8'(nw));
            nw++;
        end
        // one byte sits in rx_data, the FIFO holds the rest up to DEPTH-2
        n_checks++;
        if (nw != 15 || bus.ioctl_wait !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_wait_level: got writes=%0d wait=%b expected 15 1", nw, bus.ioctl_wait);
        end
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        n_checks++;
        if (bus.ioctl_wait !== 1'b1 || bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h10) begin
            n_fail++;
            $display("FAIL bp_hold: got wait=%b valid=%b data=%h expected 1 1 10",
                     bus.ioctl_wait, bus.rx_valid, bus.rx_data);
        end
        tick();
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 3000 && acc_d.size() < 20; i++) begin
            if (nw < 20 && !bus.ioctl_wait) begin
                file_write(8'h10 + 8'(nw));
                nw++;
            end else begin
                tick();
            end
        end
        n_checks++;
        if (acc_d.size() != 20) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected 20", acc_d.size());
            return;
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (acc_d[i] !== 8'h10 + 8'(i)) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h expected %h", i, acc_d[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_lf_filter();
        logic [7:0] exp_q[$];
`ifdef SERIAL_LOAD_LF_FILTER_EN
        exp_q = '{8'h58, 8'h0D};
`else
        exp_q = '{8'h58, 8'h0D, 8'h0A};
`endif
        do_reset();
        bus.load_from = 1'b0;
        bus.ioctl_download = 1'b1;
        bus.rx_ready = 1'b1;
        tick();
        clear_mon();
        file_write(8'h58);
        file_write(8'h0D);
        file_write(8'h0A);
        for (int i = 0; i < CG + LG + 40; i++) tick();
        n_checks++;
        if (acc_d.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL lf_count: got %0d expected %0d", acc_d.size(), exp_q.size());
            return;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (acc_d[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL lf_byte[%0d]: got %h expected %h", i, acc_d[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_uart();
        int n;
        do_reset();
        bus.load_from = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.rx_ready = 1'b0;
        tick();
        tick();
        uart_pulse(8'h31);
        @(negedge clk);
        n_checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h31) begin
            n_fail++;
            $display("FAIL uart_latency: got valid=%b data=%h expected 1 31", bus.rx_valid, bus.rx_data);
        end
        tick();
        uart_pulse(8'h32);
        @(negedge clk);
        n_checks++;
        if (bus.rx_data !== 8'h31 || bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL uart_overrun: got data=%h overrun=%b expected 31 1", bus.rx_data, bus.overrun);
        end
        do_reset();
        bus.rx_ready = 1'b1;
        tick();
        tick();
        clear_mon();
        n = cyc;
        uart_pulse(8'h31);
        uart_pulse(8'h32);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (acc_d.size() != 2 || acc_d[0] !== 8'h31 || acc_d[1] !== 8'h32 ||
            acc_r[0] != n + 1 || acc_r[1] != n + 2 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL uart_back_to_back: got n=%0d overrun=%b expected 2 bytes 31@%0d 32@%0d overrun 0",
                     acc_d.size(), bus.overrun, n + 1, n + 2);
        end
        bus.load_from = 1'b0;
        tick();
        tick();
        clear_mon();
        uart_pulse(8'h77);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (acc_d.size() != 0 || bus.rx_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL uart_discard: got n=%0d valid=%b overrun=%b expected 0 0 0",
                     acc_d.size(), bus.rx_valid, bus.overrun);
        end
    endtask

    task automatic test_source_switch();
        int n;
        do_reset();
        bus.load_from = 1'b0;
        bus.ioctl_download = 1'b1;
        bus.rx_ready = 1'b0;
        tick();
        clear_mon();
        file_write(8'h41);
        tick();
        bus.load_from = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        n_checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h41) begin
            n_fail++;
            $display("FAIL switch_inflight: got valid=%b data=%h expected 1 41", bus.rx_valid, bus.rx_data);
        end
        tick();
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 10 && acc_d.size() < 1; i++) tick();
        tick();
        tick();
        n = cyc;
        uart_pulse(8'h55);
        for (int i = 0; i < 10 && acc_d.size() < 2; i++) tick();
        n_checks++;
        if (acc_d.size() != 2 || acc_d[0] !== 8'h41 || acc_d[1] !== 8'h55 || acc_r[1] != n + 1) begin
            n_fail++;
            $display("FAIL switch_uart: got n=%0d expected 41 then 55@%0d", acc_d.size(), n + 1);
        end
    endtask

    task automatic test_random(input int round);
        int         nb;
        int         base;
        int         idx;
        int         prev_a;
        int         prev_g;
        logic [7:0] dat[8];
        int         w[8];
        int         er[8];
        int         ea[8];
        bit         rdy_pat[HOR];
        do_reset();
        bus.load_from = 1'b0;
        bus.ioctl_download = 1'b1;
        bus.rx_ready = 1'b0;
        tick();
        clear_mon();
        nb = $urandom_range(4, 8);
        for (int i = 0; i < nb; i++) begin
            dat[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0 || dat[i] == 8'h0A) dat[i] = 8'h0D;
            w[i] = (i == 0 ? 1 : w[i-1]) + $urandom_range(1, 15);
        end
        for (int c = 0; c < HOR; c++) rdy_pat[c] = (c >= HOR - 300) || ($urandom_range(0, 9) < 6);
        // reference: a byte is offered once written (+2) and once the previous gap has elapsed
        prev_a = -1000;
        prev_g = 0;
        for (int i = 0; i < nb; i++) begin
            er[i] = (w[i] + 2 > prev_a + prev_g + 2) ? w[i] + 2 : prev_a + prev_g + 2;
            ea[i] = er[i];
            while (ea[i] < HOR - 1 && !rdy_pat[ea[i]]) ea[i]++;
            prev_a = ea[i];
            prev_g = (dat[i] == 8'h0D) ? LG : CG;
        end
        base = cyc;
        idx = 0;
        for (int c = 0; c < HOR; c++) begin
            bus.rx_ready = rdy_pat[c];
            if (idx < nb && c == w[idx]) begin
                bus.ioctl_wr = 1'b1;
                bus.ioctl_data = dat[idx];
                idx++;
            end else begin
                bus.ioctl_wr = 1'b0;
            end
            tick();
        end
        bus.ioctl_wr = 1'b0;
        n_checks++;
        if (acc_d.size() != nb) begin
            n_fail++;
            $display("FAIL rand%0d_count: got %0d expected %0d", round, acc_d.size(), nb);
            return;
        end
        for (int i = 0; i < nb; i++) begin
            n_checks++;
            if (acc_d[i] !== dat[i] || acc_r[i] - base != er[i] || acc_a[i] - base != ea[i]) begin
                n_fail++;
                $display("FAIL rand%0d_byte[%0d]: got %h rise=%0d acc=%0d expected %h rise=%0d acc=%0d",
                         round, i, acc_d[i], acc_r[i] - base, acc_a[i] - base, dat[i], er[i], ea[i]);
            end
        end
    endtask

    initial begin
        bus.load_from = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index = 8'h00;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_data = 8'h00;
        bus.uart_data = 8'h00;
        bus.uart_valid = 1'b0;
        bus.rx_ready = 1'b0;
        test_reset();
        test_file_ar();
        test_backpressure();
        test_lf_filter();
        test_uart();
        test_source_switch();
        test_random(0);
        test_random(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
